des_sbox_engine: RTL
====================

Name: des_sbox_engine

Overview:
- Sequential DES substitution unit. Applies all eight FIPS 46-3 S-boxes (S1..S8) to one 48-bit expanded, key-mixed half-block and returns the 32-bit result.
- LANES S-box lookups run per cycle, so area and latency trade off through one parameter.
- Sits between the E-expansion/key-XOR stage and the P-permutation in the round datapath.
- Uses valid/ready handshakes on both sides.

Parameters:
- LANES, 2, number of S-box lookups per cycle; legal values 1, 2, 4, 8.
- PASSES, 8/LANES, derived and not overridable; number of substitution cycles per block.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  engine can accept a block.
- in_data  input  48  expanded half-block; bits [47:42] feed S1, ..., bits [5:0] feed S8.
- out_valid  output  1  out_data holds a completed result.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  32  substituted word; S1 result in [31:28], ..., S8 result in [3:0].
- busy  output  1  high in BUSY and DONE states.

Behaviour:
- S-box addressing, per 6-bit group b[5:0]:
  - row = {b[5], b[0]}; col = b[4:1].
  - Output nibble is the FIPS 46-3 table entry for that S-box.
  - All 8 tables are stored as combinational constant ROMs.
  - Lane j in pass p evaluates S-box number p*LANES + j + 1.
- Reset (rst high at an edge):
  - state = IDLE; out_valid = 0; out_data = 0; internal shift and pass counter = 0; busy = 0.
  - in_ready is 0 while rst is high.
  - Reset mid-operation discards the block in flight. No partial result is ever presented.
- FSM states:
  - IDLE:
    - in_ready = 1.
    - On in_valid & in_ready: capture in_data into a 48-bit work register, clear the pass counter, go to BUSY.
  - BUSY:
    - in_ready = 0.
    - Each cycle, look up the top 6*LANES bits of the work register.
    - Shift the work register left by 6*LANES.
    - Shift the 4*LANES result bits into the accumulator from the LSB side.
    - Increment the pass counter.
    - After pass PASSES-1: load out_data from the accumulator, set out_valid, go to DONE.
  - DONE:
    - out_valid = 1; out_data held stable.
    - On out_ready: clear out_valid, go to IDLE.
    - A new block cannot be accepted in the same cycle.
- Latency:
  - Acceptance edge E0; out_valid is high after edge E_PASSES.
  - LANES=8: 1 cycle. LANES=2: 4 cycles. LANES=1: 8 cycles.
- Throughput: one block per PASSES+2 cycles when out_ready is held high.
- Pass counter width: clog2(PASSES), minimum 1 bit. It wraps only through reset or a return to IDLE.
- in_data changes while not in IDLE are ignored.
- in_valid held low: the engine stays in IDLE indefinitely.
- out_ready held low: the engine stays in DONE indefinitely, output stable.
- Illegal LANES: elaboration error.

Test Plan:
- in_data=48'h0 (LANES=2) -> out_data=32'hEFA72C4D, out_valid rises 4 cycles after the acceptance edge.
- in_data=48'hFFFFFFFFFFFF -> out_data=32'hD9CE3DCB. Repeat for LANES=1, 4, 8 with latency 8, 2, 1 respectively.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_data unchanged, in_ready=0 throughout. Assert out_ready -> in_ready=1 on the following cycle.
- Reset mid-operation: assert rst during pass 2 with LANES=1 -> next cycle out_valid=0, out_data=0, state IDLE. The next block (48'h0) yields 32'hEFA72C4D.
- Back-to-back: two blocks (all-zeros then all-ones) with in_valid and out_ready held high -> results in order, second result PASSES+2 cycles after the first.
- Random regression: 1000 random 48-bit blocks compared against a software DES S-layer model, for each legal LANES value.

Source files
------------

// File: rtl/des_sbox_engine.sv
// DES S-layer: eight FIPS 46-3 S-boxes applied to a 48-bit expanded half-block,
// LANES lookups per cycle over PASSES = 8/LANES cycles, valid/ready on both sides.
//
//   state | meaning
//   IDLE  | ready for a new block
//   BUSY  | running substitution passes
//   DONE  | result presented, waiting for out_ready

module des_sbox_engine #(
   parameter int LANES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [47:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        busy
);

   localparam int PASSES = 8 / LANES;
   localparam int CW     = (PASSES > 1) ? $clog2(PASSES) : 1;

   if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
      $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
   end

   // Each box is 64 nibbles, entry 0 in the most significant position, indexed by {row, col}.
   localparam logic [0:63][3:0] S1 =
      256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
   localparam logic [0:63][3:0] S2 =
      256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
   localparam logic [0:63][3:0] S3 =
      256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
   localparam logic [0:63][3:0] S4 =
      256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
   localparam logic [0:63][3:0] S5 =
      256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
   localparam logic [0:63][3:0] S6 =
      256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
   localparam logic [0:63][3:0] S7 =
      256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
   localparam logic [0:63][3:0] S8 =
      256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

   localparam logic [0:7][0:63][3:0] SBOX = {S1, S2, S3, S4, S5, S6, S7, S8};

   function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] b);
      logic [5:0] idx;
      idx = {b[5], b[0], b[4:1]};
      return SBOX[box][idx];
   endfunction

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t              state, state_next;
   logic [47:0]         work;
   logic [31:0]         acc;
   logic [31:0]         acc_next;
   logic [CW-1:0]       pass_cnt;
   logic [4*LANES-1:0]  lane_out;
   logic                last_pass;

   // Lane 0 handles the lowest-numbered box of the pass, so it lands in the upper nibble.
   for (genvar j = 0; j < LANES; j++) begin : g_lane
      logic [2:0] box;
      assign box = 3'(32'(pass_cnt) * LANES + j);
      assign lane_out[4*(LANES-1-j) +: 4] = sbox_lookup(box, work[47-6*j -: 6]);
   end

   assign last_pass = (pass_cnt == CW'(PASSES - 1));
   assign acc_next  = (acc << (4 * LANES)) | 32'(lane_out);
   assign in_ready  = (state == IDLE) && !rst;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid) state_next = BUSY;
         BUSY:    if (last_pass) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         work      <= '0;
         acc       <= '0;
         pass_cnt  <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  work     <= in_data;
                  acc      <= '0;
                  pass_cnt <= '0;
               end
            end
            BUSY: begin
               work     <= work << (6 * LANES);
               acc      <= acc_next;
               pass_cnt <= pass_cnt + CW'(1);
               if (last_pass) begin
                  out_data  <= acc_next;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: out_valid <= 1'b0;
         endcase
      end
   end

endmodule
